// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, alternating on ties,
// holding the memory-side request stable until acknowledged, and aborting on a stuck memory.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_wstrb,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_err
);

  // state  | meaning
  // IDLE   | port free, arbitrate between pending requesters
  // SERV_D | data access owns the port, waiting for mem_ready
  // SERV_I | fetch owns the port, waiting for mem_ready
  // RESP   | owner's ready pulses; no arbitration so a stale request is never re-granted
  typedef enum logic [1:0] {IDLE, SERV_D, SERV_I, RESP} state_t;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic        last_i_q;
  logic [7:0]  wdog_q;
  logic        mem_valid_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wstrb_q;
  logic [31:0] if_rdata_q;
  logic [31:0] dm_rdata_q;
  logic        if_ready_q;
  logic        dm_ready_q;
  logic        bus_err_q;

  logic data_pend;
  logic grant_d;
  logic grant_i;
  logic wdog_expired;

  always_comb begin
    data_pend    = dm_read | dm_write;
    grant_d      = data_pend & (~if_req | last_i_q);
    grant_i      = if_req & (~data_pend | ~last_i_q);
    wdog_expired = (wdog_q == WDOG_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_i_q    <= 1'b1;
      wdog_q      <= 8'd0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'h0;
      if_rdata_q  <= 32'd0;
      dm_rdata_q  <= 32'd0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q     <= SERV_D;
            last_i_q    <= 1'b0;
            wdog_q      <= 8'd0;
            mem_valid_q <= 1'b1;
            mem_we_q    <= dm_write;
            mem_addr_q  <= dm_addr;
            mem_wdata_q <= dm_wdata;
            mem_wstrb_q <= dm_wstrb;
          end else if (grant_i) begin
            state_q     <= SERV_I;
            last_i_q    <= 1'b1;
            wdog_q      <= 8'd0;
            mem_valid_q <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= 32'd0;
            mem_wstrb_q <= 4'h0;
          end
        end
        SERV_D, SERV_I: begin
          if (mem_ready || wdog_expired) begin
            state_q     <= RESP;
            mem_valid_q <= 1'b0;
            bus_err_q   <= ~mem_ready;
            if (state_q == SERV_I) begin
              if_ready_q <= 1'b1;
              if_rdata_q <= mem_ready ? mem_rdata : 32'd0;
            end else begin
              dm_ready_q <= 1'b1;
              // a completed store leaves the last load value in place
              if (!mem_ready)
                dm_rdata_q <= 32'd0;
              else if (!mem_we_q)
                dm_rdata_q <= mem_rdata;
            end
          end else begin
            wdog_q <= wdog_q + 8'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign bus_err   = bus_err_q;
  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = data_pend & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized concurrent traffic,
// responses checked by a scoreboard fed from a memory/arbitration reference model.
module tb_mem_port_arbiter;

  localparam int unsigned TO = 8;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_err;

  logic        dev_ready;
  logic [31:0] dev_rdata;
  logic        man_ready;
  logic [31:0] man_rdata;
  assign mem_ready = dev_ready | man_ready;
  assign mem_rdata = man_ready ? man_rdata : dev_rdata;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        berr;
  } exp_t;

  exp_t        if_q[$];
  exp_t        dm_q[$];
  logic [32:0] grant_log[$];
  logic [31:0] ref_mem[bit [31:0]];
  logic [31:0] dev_mem[bit [31:0]];
  logic [31:0] last_ld;
  logic        dev_en;
  int          dev_lat;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic b);
    exp_t e;
    e.rdata = r;
    e.berr  = b;
    return e;
  endfunction

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0050_0093 : ((a ^ 32'h1357_0000) + 32'h1);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] ws);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] dev_read(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
  endfunction

  // Memory device: answers each new request after dev_lat wait cycles (random when negative).
  initial begin
    logic [31:0] ca, cw;
    logic [3:0]  cs;
    logic        cwe;
    int          lat;
    dev_ready = 1'b0;
    dev_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_valid === 1'b1 && dev_en) begin
        ca  = mem_addr;
        cw  = mem_wdata;
        cs  = mem_wstrb;
        cwe = mem_we;
        lat = (dev_lat < 0) ? int'($urandom_range(0, 3)) : dev_lat;
        repeat (lat) @(negedge clk);
        check("mem_addr_hold", 64'(mem_addr), 64'(ca));
        check("mem_wdata_hold", 64'(mem_wdata), 64'(cw));
        check("mem_ctl_hold", 64'({mem_valid, mem_we, mem_wstrb}), 64'({1'b1, cwe, cs}));
        if (cwe) begin
          dev_mem[ca] = merge(dev_read(ca), cw, cs);
          dev_rdata   = $urandom;
        end else begin
          dev_rdata = (ca < 32'h1000) ? fetch_word(ca) : dev_read(ca);
        end
        dev_ready = 1'b1;
        @(negedge clk);
        dev_ready = 1'b0;
        dev_rdata = $urandom;
      end
    end
  end

  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (mem_valid === 1'b1 && !prev_valid) grant_log.push_back({mem_we, mem_addr});
    prev_valid = (mem_valid === 1'b1);
  end

  // Scoreboard monitor: every ready pulse consumes one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (if_ready === 1'b1) begin
      if (if_q.size() == 0) check("if_unexpected_ready", 64'(if_ready), 64'd0);
      else begin
        e = if_q.pop_front();
        check("if_rdata", 64'(if_rdata), 64'(e.rdata));
        check("if_bus_err", 64'(bus_err), 64'(e.berr));
      end
    end
    if (dm_ready === 1'b1) begin
      if (dm_q.size() == 0) check("dm_unexpected_ready", 64'(dm_ready), 64'd0);
      else begin
        e = dm_q.pop_front();
        check("dm_rdata", 64'(dm_rdata), 64'(e.rdata));
        check("dm_bus_err", 64'(bus_err), 64'(e.berr));
      end
    end
    if (bus_err === 1'b1 && if_ready !== 1'b1 && dm_ready !== 1'b1)
      check("bus_err_without_ready", 64'(bus_err), 64'd0);
  end

  task automatic run_fetch(input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      logic [31:0] a;
      int w;
      a = 32'h100 + 32'(4 * $urandom_range(0, 63));
      if_addr = a;
      if_req  = 1'b1;
      if_q.push_back(mk(fetch_word(a), 1'b0));
      w = 0;
      do begin @(negedge clk); w++; end while (!if_ready && w < 40);
      check("if_txn_done", 64'(if_ready), 64'd1);
      if (gaps && $urandom_range(0, 1) == 1) begin
        if_req = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    if_req = 1'b0;
  endtask

  task automatic run_data(input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      logic [31:0] a, wd;
      logic [3:0]  ws;
      int kind, w;
      a    = 32'h2000 + 32'(4 * $urandom_range(0, 15));
      wd   = $urandom;
      ws   = 4'($urandom_range(1, 15));
      kind = $urandom_range(0, 5);
      dm_addr  = a;
      dm_wdata = wd;
      dm_wstrb = ws;
      dm_read  = (kind < 3) || (kind == 5);
      dm_write = (kind >= 3);
      if (dm_write) ref_mem[a] = merge(ref_read(a), wd, ws);
      else last_ld = ref_read(a);
      dm_q.push_back(mk(last_ld, 1'b0));
      w = 0;
      do begin @(negedge clk); w++; end while (!dm_ready && w < 40);
      check("dm_txn_done", 64'(dm_ready), 64'd1);
      if (gaps && $urandom_range(0, 1) == 1) begin
        dm_read  = 1'b0;
        dm_write = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    dm_read  = 1'b0;
    dm_write = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit actual=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int n, vcyc, gaps, pulses;
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_read = 1'b0; dm_write = 1'b0;
    dm_addr = '0; dm_wdata = '0; dm_wstrb = '0; man_ready = 1'b0; man_rdata = '0;
    dev_en = 1'b1; dev_lat = 1; last_ld = '0;
    repeat (3) @(negedge clk);
    check("rst_ctl", 64'({mem_valid, mem_we, mem_wstrb, if_ready, dm_ready, bus_err,
                          stall_if, stall_mem}), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_rdata", 64'({if_rdata, dm_rdata}), 64'd0);
    rst_n = 1'b1;

    // Tie straight after reset: data wins, fetch follows.
    grant_log.delete();
    if_req = 1'b1; if_addr = 32'h104; dm_read = 1'b1; dm_addr = 32'h2000;
    if_q.push_back(mk(fetch_word(32'h104), 1'b0));
    last_ld = ref_read(32'h2000);
    dm_q.push_back(mk(last_ld, 1'b0));
    n = 0; gaps = 0;
    while (!dm_ready && n < 50) begin @(negedge clk); n++; if (!stall_if) gaps++; end
    check("tie_dm_done", 64'(dm_ready), 64'd1);
    dm_read = 1'b0;
    while (!if_ready && n < 100) begin @(negedge clk); n++; if (!stall_if && !if_ready) gaps++; end
    check("tie_if_done", 64'(if_ready), 64'd1);
    if_req = 1'b0;
    check("tie_stall_if", 64'(gaps), 64'd0);
    check("tie_first_grant", 64'(grant_log[0]), 64'({1'b0, 32'h2000}));
    check("tie_second_grant", 64'(grant_log[1]), 64'({1'b0, 32'h104}));

    // Fetch alone, memory answers one cycle after valid.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    if_q.push_back(mk(32'h0050_0093, 1'b0));
    n = 0; vcyc = 0;
    while (!if_ready && n < 50) begin @(negedge clk); n++; if (mem_valid) vcyc++; end
    if_req = 1'b0;
    check("fetch_done", 64'(if_ready), 64'd1);
    check("fetch_valid_cycles", 64'(vcyc), 64'd2);
    check("fetch_rdata", 64'(if_rdata), 64'h0050_0093);

    // Store with partial strobes, two wait cycles.
    dev_lat = 2;
    @(negedge clk);
    dm_write = 1'b1; dm_addr = 32'h3004; dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'b0011;
    ref_mem[32'h3004] = merge(ref_read(32'h3004), 32'hDEAD_BEEF, 4'b0011);
    dm_q.push_back(mk(last_ld, 1'b0));
    n = 0;
    while (!mem_valid && n < 20) begin @(negedge clk); n++; end
    check("st_mem_fields", 64'({mem_we, mem_wstrb, mem_addr}), 64'({1'b1, 4'b0011, 32'h3004}));
    check("st_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    while (!dm_ready && n < 50) begin @(negedge clk); n++; end
    dm_write = 1'b0;
    check("st_done", 64'(dm_ready), 64'd1);
    check("st_dm_rdata_kept", 64'(dm_rdata), 64'(last_ld));

    // Both pending continuously with zero-wait memory: grants alternate, fetch first (data went last).
    dev_lat = 0;
    @(negedge clk);
    grant_log.delete();
    fork
      run_fetch(4, 1'b0);
      run_data(4, 1'b0);
    join
    check("fair_grant_count", 64'(grant_log.size()), 64'd8);
    for (int k = 0; k < 8; k++)
      check($sformatf("fair_grant_%0d_is_fetch", k), 64'(grant_log[k][31:0] < 32'h1000),
            64'(k % 2 == 0));

    // Watchdog abort on a memory that never answers.
    @(negedge clk);
    dev_en = 1'b0;
    dm_read = 1'b1; dm_write = 1'b0; dm_addr = 32'h2010;
    last_ld = 32'd0;
    dm_q.push_back(mk(32'd0, 1'b1));
    n = 0; vcyc = 0; gaps = 0;
    while (!dm_ready && n < 50) begin
      @(negedge clk); n++;
      if (mem_valid) vcyc++;
      if (!dm_ready && !stall_mem) gaps++;
    end
    check("to_done", 64'(dm_ready), 64'd1);
    check("to_valid_cycles", 64'(vcyc), 64'(TO));
    check("to_bus_err", 64'(bus_err), 64'd1);
    check("to_dm_rdata", 64'(dm_rdata), 64'd0);
    check("to_stall_mem_wait", 64'(gaps), 64'd0);
    check("to_stall_mem_resp", 64'(stall_mem), 64'd0);
    dm_read = 1'b0;
    @(negedge clk);
    check("to_idle", 64'({mem_valid, bus_err, dm_ready, if_ready}), 64'd0);

    // Reset during the third wait cycle of a fetch; late mem_ready must be ignored.
    if_req = 1'b1; if_addr = 32'h140;
    n = 0;
    while (!mem_valid && n < 20) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; if_req = 1'b0; last_ld = 32'd0;
    check("rst_serv_valid", 64'(mem_valid), 64'd0);
    check("rst_serv_rdata", 64'({if_rdata, dm_rdata}), 64'd0);
    man_ready = 1'b1; man_rdata = 32'hCAFE_F00D; pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (if_ready || dm_ready || bus_err || mem_valid) pulses++;
    end
    man_ready = 1'b0;
    check("rst_serv_no_activity", 64'(pulses), 64'd0);

    // Random concurrent traffic with random memory latency.
    dev_en = 1'b1; dev_lat = -1;
    @(negedge clk);
    fork
      run_fetch(40, 1'b1);
      run_data(40, 1'b1);
    join
    repeat (5) @(negedge clk);
    check("if_queue_drained", 64'(if_q.size()), 64'd0);
    check("dm_queue_drained", 64'(dm_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles to wait for mem_ready before aborting (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset: synchronous, active-low.
REQ-004 SHALL have ports if_req input 1 (fetch request) and if_addr input 32 (fetch address).
REQ-005 SHALL have ports if_rdata output 32 (fetched word) and if_ready output 1 (fetch complete, one-cycle pulse).
REQ-006 SHALL have ports dm_read input 1 (load, driven by MemRead) and dm_write input 1 (store, driven by MemWrite).
REQ-007 SHALL have ports dm_addr input 32, dm_wdata input 32 and dm_wstrb input 4 (byte enables).
REQ-008 SHALL have ports dm_rdata output 32 (load data) and dm_ready output 1 (data access complete, one-cycle pulse).
REQ-009 SHALL have ports mem_valid output 1, mem_we output 1, mem_addr output 32, mem_wdata output 32 and mem_wstrb output 4, forming the shared memory port.
REQ-010 SHALL have ports mem_rdata input 32 and mem_ready input 1 (memory response).
REQ-011 SHALL have outputs stall_if 1, stall_mem 1 and bus_err 1 (timeout abort, one-cycle pulse).

Function
REQ-012 SHALL implement the FSM states IDLE, SERV_D, SERV_I and RESP, all held in registers.
REQ-013 IDLE, data pending (dm_read|dm_write) and fetch not pending: go to SERV_D.
REQ-014 IDLE, fetch pending (if_req) and data not pending: go to SERV_I.
REQ-015 IDLE, both pending: grant the requester not granted last, using a last_grant register.
REQ-016 last_grant SHALL be updated on every entry to SERV_D or SERV_I.
REQ-017 On entry to SERV_x, the requester's address/wdata/wstrb SHALL be registered onto mem_*.
REQ-018 On entry to SERV_x, mem_valid SHALL be set to 1.
REQ-019 On entry to SERV_x, mem_we SHALL be set to dm_write for SERV_D and 0 for SERV_I.
REQ-020 mem_valid and all mem_* outputs SHALL be held stable in SERV_x until mem_ready is sampled high.
REQ-021 Grant latency: request seen in IDLE at edge N; mem_valid SHALL be high from cycle N+1.
REQ-022 On mem_ready high in SERV_x at edge M, the FSM SHALL go to RESP.
REQ-023 On that transition, mem_valid SHALL clear and mem_rdata SHALL be registered into if_rdata or dm_rdata.
REQ-024 The corresponding if_ready or dm_ready SHALL be high exactly in cycle M+1 (state RESP).
REQ-025 RESP SHALL always return to IDLE and SHALL perform no arbitration.
REQ-026 Requesters SHALL drop or change their request in the cycle after ready; the RESP state prevents a double grant.
REQ-027 mem_rdata SHALL be ignored for stores; dm_rdata SHALL keep its previous value after a store.
REQ-028 dm_read and dm_write both high is illegal and SHALL be treated as a store.
REQ-029 A watchdog counter SHALL clear on entry to SERV_x and increment each SERV_x cycle in which mem_ready is low.
REQ-030 When the watchdog reaches TIMEOUT, the FSM SHALL go to RESP, clear mem_valid and pulse bus_err plus the owner's ready.
REQ-031 On a timeout, the owner's rdata SHALL be 32'h0000_0000.
REQ-032 mem_ready while in IDLE or RESP SHALL be ignored.
REQ-033 stall_if SHALL equal if_req & ~if_ready (combinational).
REQ-034 stall_mem SHALL equal (dm_read|dm_write) & ~dm_ready (combinational).
REQ-035 Requests deasserted while not granted SHALL be dropped silently.
REQ-036 A granted transaction SHALL complete even if its request drops mid-service.

Reset
REQ-037 When rst_n is low at a clock edge, the block SHALL enter IDLE with last_grant set to instruction, so data wins the first tie.
REQ-038 Reset SHALL clear the watchdog and set mem_valid, mem_we, if_ready, dm_ready and bus_err to 0.
REQ-039 Reset SHALL set mem_addr, mem_wdata, if_rdata and dm_rdata to 0 and mem_wstrb to 4'h0.
REQ-040 Reset asserted mid-transaction SHALL abort it; mem_valid SHALL be 0 after that edge and no ready SHALL pulse.

Verification
REQ-041 Fetch only: if_req=1, if_addr=0x100, mem_ready one cycle after mem_valid with mem_rdata=0x00500093 -> mem_valid high 2 cycles, then if_ready pulse, if_rdata=0x00500093.
REQ-042 Tie after reset: if_req=1, dm_read=1, dm_addr=0x2000 in the same cycle -> data served first (mem_addr=0x2000, mem_we=0), then fetch served; stall_if high throughout.
REQ-043 Fairness: both requesters pending continuously, zero-wait memory -> grants alternate D,I,D,I and no requester waits more than one other transaction.
REQ-044 Store: dm_write=1, dm_addr=0x3004, dm_wdata=0xDEADBEEF, dm_wstrb=4'b0011 -> mem_we=1 with those exact values held until mem_ready; dm_ready pulses; dm_rdata unchanged.
REQ-045 Timeout: TIMEOUT=8, data request, mem_ready held low -> after 8 SERV_D cycles, bus_err and dm_ready pulse together, dm_rdata=0, FSM back in IDLE.
REQ-046 Reset in SERV_I (rst_n low for 1 cycle at wait cycle 3) -> mem_valid=0 next cycle, no if_ready pulse, a later mem_ready is ignored.
